// File: rtl/cmp_pkg.sv
// Shared encodings for the compare-scan controller: operation modes, FSM states
// and default sample/length widths.
package cmp_pkg;

  localparam int unsigned W_DEF  = 4;
  localparam int unsigned LW_DEF = 4;

  typedef enum logic [1:0] {
    MODE_MAX = 2'b00,
    MODE_MIN = 2'b01,
    MODE_CNT = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FIRST = 2'b01,
    SCAN  = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/cmp4_core.sv
// Unsigned magnitude comparator, purely combinational (zero latency, no flow control).
// Exactly one of gt/eq/lt is high for any operand pair.
module cmp4_core
  import cmp_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_scan_ctrl.sv
// Streams a burst through one shared comparator to find max, min or key-match count.
// done follows the last accept by one cycle; in_valid low stalls the scan in place.
module cmp_scan_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  key,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result,
  output logic [LW-1:0] result_idx,
  output logic [LW-1:0] eq_count
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [W-1:0]  key_q, key_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [W-1:0]  result_q, result_d;
  logic [LW-1:0] result_idx_q, result_idx_d;
  logic [LW-1:0] eq_count_q, eq_count_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic          last_sample;
  logic [W-1:0]  cmp_b;
  logic          cmp_gt, cmp_eq, cmp_lt;

  // Single comparator: the running extremum in max/min, the latched key in count mode.
  assign cmp_b = (mode_q == MODE_CNT) ? key_q : result_q;

  cmp4_core #(.W(W)) u_cmp (
    .a  (in_data),
    .b  (cmp_b),
    .gt (cmp_gt),
    .eq (cmp_eq),
    .lt (cmp_lt)
  );

  assign in_ready    = (state_q == FIRST) || (state_q == SCAN);
  assign accept      = in_ready && in_valid;
  assign last_sample = (idx_q == (len_q - LW'(1)));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    key_d        = key_q;
    len_d        = len_q;
    idx_d        = idx_q;
    result_d     = result_q;
    result_idx_d = result_idx_q;
    eq_count_d   = eq_count_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((len == '0) || (mode_e'(mode) == MODE_RSV)) begin
            err_d        = 1'b1;
            result_d     = '0;
            result_idx_d = '0;
            eq_count_d   = '0;
            state_d      = DONE;
          end else begin
            mode_d       = mode_e'(mode);
            key_d        = key;
            len_d        = len;
            idx_d        = '0;
            result_d     = '0;
            result_idx_d = '1;
            eq_count_d   = '0;
            err_d        = 1'b0;
            state_d      = FIRST;
          end
        end
      end

      FIRST, SCAN: begin
        if (accept) begin
          idx_d = idx_q + LW'(1);
          case (mode_q)
            MODE_MAX: begin
              // Strict compare keeps the earliest index on ties.
              if ((state_q == FIRST) || cmp_gt) begin
                result_d     = in_data;
                result_idx_d = idx_q;
              end
            end
            MODE_MIN: begin
              if ((state_q == FIRST) || cmp_lt) begin
                result_d     = in_data;
                result_idx_d = idx_q;
              end
            end
            default: begin
              if (cmp_eq) begin
                eq_count_d = eq_count_q + LW'(1);
                if (eq_count_q == '0) begin
                  result_idx_d = idx_q;
                end
              end
            end
          endcase
          if (last_sample) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == FIRST) || (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= MODE_MAX;
      key_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      result_q     <= '0;
      result_idx_q <= '0;
      eq_count_q   <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      key_q        <= key_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      result_q     <= result_d;
      result_idx_q <= result_idx_d;
      eq_count_q   <= eq_count_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign result     = result_q;
  assign result_idx = result_idx_q;
  assign eq_count   = eq_count_q;

endmodule

// File: doc/cmp_scan_ctrl.md
Name: cmp_scan_ctrl

Overview:
Sequencing controller that streams a burst of 4-bit samples through one shared magnitude comparator to find the maximum, the minimum, or the count of samples equal to a key. It sits between a sample source (valid/ready) and the status/result consumer. The comparator is the block's only arithmetic resource. Each accepted sample gets exactly one comparison.

Parameters:
W, 4, sample and key width in bits
LW, 4, width of the length, index and count fields; the maximum burst is 2^LW-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  begin an operation; sampled only in IDLE
mode  input  2  operation select: 00 = max, 01 = min, 10 = count-equal, 11 = reserved
key  input  W  compare key for count-equal mode
len  input  LW  number of samples in the burst
in_valid  input  1  sample valid
in_data  input  W  sample value
in_ready  output  1  controller accepts a sample this cycle
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
err  output  1  error flag for the last operation (len==0 or mode==11)
result  output  W  extremum value; 0 in count mode
result_idx  output  LW  index of the extremum, or of the first match in count mode; all-ones if no match
eq_count  output  LW  number of samples equal to key (count mode only; 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. in_ready, busy, done, err, result, result_idx, eq_count all 0. Reset mid-burst abandons the burst; the source must restart.
- Sample acceptance: a sample is accepted on a cycle where in_valid && in_ready. The index counter starts at 0 and increments per accepted sample.
- States:
  - IDLE: in_ready=0, busy=0.
    - start=1 with len!=0 and mode!=11: latch mode, key, len; clear eq_count; set result_idx to all-ones; clear err; go to FIRST.
    - start=1 with len==0 or mode==11: set err=1, result=0, result_idx=0, eq_count=0; go to DONE.
  - FIRST: in_ready=1, busy=1.
    - On accept in max/min mode: result<=in_data, result_idx<=0.
    - On accept in count mode: compare in_data with key; on eq, eq_count<=1 and result_idx<=0.
    - If len==1, go to DONE; else go to SCAN.
  - SCAN: in_ready=1, busy=1. Comparator operands are a=in_data and b=result (max/min) or b=key (count).
    - max: replace when gt (strict). Ties keep the earliest index.
    - min: replace when lt (strict). Ties keep the earliest index.
    - count: on eq, eq_count++ and capture result_idx on the first match only.
    - Go to DONE on the cycle the len-th sample is accepted.
  - DONE: done=1 for exactly one cycle, busy=0, in_ready=0; next state is IDLE.
- Result registers hold their values until the next accepted start.
- Latency: done asserts the cycle after the last accept, so total time = len accept cycles + 1.
- start is ignored while busy. in_valid is ignored outside FIRST/SCAN. in_valid=0 stalls without changing state.
- eq_count cannot overflow because len ≤ 2^LW-1.
- All outputs are registered except in_ready, which decodes from state.

Decomposition:
- Shared package cmp_pkg holds:
  - the mode encodings: MODE_MAX, MODE_MIN, MODE_CNT, MODE_RSV;
  - the state enum IDLE/FIRST/SCAN/DONE;
  - the default W and LW.
- One sub-module, cmp4_core: purely combinational. Inputs a[W], b[W]; outputs gt, eq, lt, exactly one high. The controller instantiates one cmp4_core and muxes its b operand.

Test Plan:
- Max scan: mode=00, len=5, samples 3,9,2,9,7 with in_valid held high -> done 6 cycles after start accept; result=9, result_idx=1, err=0.
- Min scan with stalls: mode=01, len=4, samples 8,4,4,12 with in_valid low for 2 cycles between samples -> result=4, result_idx=1; in_ready stays high during stalls; done pulses exactly once.
- Count-equal: mode=10, key=6, len=6, samples 1,6,6,0,6,15 -> eq_count=3, result_idx=1, result=0. A second run with no 6s -> eq_count=0, result_idx=4'hF.
- Error paths: start with len=0 -> done next cycle, err=1, in_ready never high. start with mode=11, len=3 -> same behaviour. A following valid run clears err.
- Reset mid-burst: assert rst_n=0 after 2 of 5 samples -> all outputs 0 immediately (async). After release, a new len=1 burst with sample 14 -> result=14, result_idx=0.
- Ignored start: pulse start while in SCAN with different mode/len -> the current operation completes with its original parameters; no extra done pulse.
